// File: rtl/complex_delay_line.sv
// Complex-sample delay line: DEPTH stages of (re, im, valid) with a runtime output tap,
// stall enable and optional saturating conjugation applied when a sample is captured.
module complex_delay_line #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clrh,
    input  logic                  enh,
    input  logic                  conjh_i,
    input  logic                  valid_i,
    input  logic [SEL_WIDTH-1:0]  delay_i,
    input  logic [DATA_WIDTH-1:0] dataRe_i,
    input  logic [DATA_WIDTH-1:0] dataIm_i,
    output logic [DATA_WIDTH-1:0] dataRe_o,
    output logic [DATA_WIDTH-1:0] dataIm_o,
    output logic                  valid_o,
    output logic                  primed_o
);

    localparam logic [DATA_WIDTH-1:0] MIN_VAL   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_VAL   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [SEL_WIDTH-1:0]  DEPTH_SEL = SEL_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_stage_re [DEPTH];
    logic [DATA_WIDTH-1:0] r_stage_im [DEPTH];
    logic [DEPTH-1:0]      r_stage_v;
    logic [SEL_WIDTH-1:0]  r_fill;

    logic [DATA_WIDTH-1:0] w_neg_im;
    logic [DATA_WIDTH-1:0] w_cap_im;
    logic [SEL_WIDTH-1:0]  w_sel;

    // Negating the most negative value would wrap; clamp it to the most positive instead.
    assign w_neg_im = (dataIm_i == MIN_VAL) ? MAX_VAL : -dataIm_i;
    assign w_cap_im = conjh_i ? w_neg_im : dataIm_i;

    always_ff @(posedge clk) begin
        if (clrh) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage_re[k] <= '0;
                r_stage_im[k] <= '0;
            end
            r_stage_v <= '0;
            r_fill    <= '0;
        end else if (enh) begin
            r_stage_re[0] <= dataRe_i;
            r_stage_im[0] <= w_cap_im;
            r_stage_v[0]  <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage_re[k] <= r_stage_re[k-1];
                r_stage_im[k] <= r_stage_im[k-1];
                r_stage_v[k]  <= r_stage_v[k-1];
            end
            if (r_fill != DEPTH_SEL) begin
                r_fill <= r_fill + SEL_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_sel = delay_i;
        if (delay_i == '0) begin
            w_sel = SEL_WIDTH'(1);
        end else if (delay_i > DEPTH_SEL) begin
            w_sel = DEPTH_SEL;
        end
    end

    // w_sel is always in 1..DEPTH, so exactly one stage matches.
    always_comb begin
        dataRe_o = '0;
        dataIm_o = '0;
        valid_o  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_sel == SEL_WIDTH'(k + 1)) begin
                dataRe_o = r_stage_re[k];
                dataIm_o = r_stage_im[k];
                valid_o  = r_stage_v[k];
            end
        end
    end

    assign primed_o = (r_fill >= w_sel);

endmodule

// File: tb/tb_complex_delay_line.sv
// Self-checking bench for complex_delay_line (DATA_WIDTH=8, DEPTH=4) using a sample scoreboard.
module tb_complex_delay_line;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          v;
    } sample_t;

    logic          clk = 1'b0;
    logic          clrh, enh, conjh_i, valid_i;
    logic [SW-1:0] delay_i;
    logic [DW-1:0] dataRe_i, dataIm_i;
    logic [DW-1:0] dataRe_o, dataIm_o;
    logic          valid_o, primed_o;

    int total = 0;
    int bad   = 0;
    int fill_m;
    sample_t q[$];
    sample_t exp_s, got_s, last_s;

    complex_delay_line #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clrh     (clrh),
        .enh      (enh),
        .conjh_i  (conjh_i),
        .valid_i  (valid_i),
        .delay_i  (delay_i),
        .dataRe_i (dataRe_i),
        .dataIm_i (dataIm_i),
        .dataRe_o (dataRe_o),
        .dataIm_o (dataIm_o),
        .valid_o  (valid_o),
        .primed_o (primed_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        got_s = '{re: dataRe_o, im: dataIm_o, v: valid_o};
    endtask

    task automatic do_clear();
        clrh = 1'b1; enh = 1'b0; conjh_i = 1'b0; valid_i = 1'b0;
        dataRe_i = '0; dataIm_i = '0;
        step();
        clrh = 1'b0;
        q.delete();
        fill_m = 0;
    endtask

    function automatic logic [DW-1:0] conj_model(input logic [DW-1:0] x);
        if (x == 8'h80) return 8'h7f;
        return 8'(0 - int'($signed(x)));
    endfunction

    task automatic test_reset();
        clrh = 1'b1; enh = 1'b1; delay_i = 3'd3;
        for (int c = 0; c < 2; c++) begin
            conjh_i = 1'($urandom); valid_i = 1'b1;
            dataRe_i = 8'($urandom); dataIm_i = 8'($urandom);
            step();
            total++;
            if (got_s !== sample_t'(0)) begin
                bad++;
                $display("FAIL reset_out cyc=%0d got=%h want=0", c, got_s);
            end
            total++;
            if (primed_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_primed cyc=%0d got=%b want=0", c, primed_o);
            end
        end
        clrh = 1'b0; q.delete(); fill_m = 0;
    endtask

    task automatic test_latency();
        do_clear();
        delay_i = 3'd3; enh = 1'b1; valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            dataRe_i = 8'(i); dataIm_i = 8'(-i);
            q.push_back('{re: dataRe_i, im: dataIm_i, v: 1'b1});
            step();
            fill_m = (fill_m < DEPTH) ? fill_m + 1 : DEPTH;
            total++;
            if (q.size() == 3) begin
                exp_s = q.pop_front();
                if (got_s !== exp_s) begin
                    bad++;
                    $display("FAIL latency_data edge=%0d got=%h want=%h", i, got_s, exp_s);
                end
            end else if (got_s !== sample_t'(0)) begin
                bad++;
                $display("FAIL latency_empty edge=%0d got=%h want=0", i, got_s);
            end
            total++;
            if (primed_o !== (fill_m >= 3)) begin
                bad++;
                $display("FAIL latency_primed edge=%0d got=%b want=%b", i, primed_o, fill_m >= 3);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        do_clear();
        delay_i = 3'd3; valid_i = 1'b1; n = 1;
        last_s = '0;
        for (int c = 0; c < 12; c++) begin
            enh = !(c == 4 || c == 5);
            dataRe_i = 8'(n); dataIm_i = 8'(-n);
            if (enh) begin
                q.push_back('{re: dataRe_i, im: dataIm_i, v: 1'b1});
                n++;
            end
            step();
            if (enh) begin
                fill_m = (fill_m < DEPTH) ? fill_m + 1 : DEPTH;
                if (q.size() == 3) begin
                    exp_s = q.pop_front();
                    total++;
                    if (got_s !== exp_s) begin
                        bad++;
                        $display("FAIL stall_data cyc=%0d got=%h want=%h", c, got_s, exp_s);
                    end
                    last_s = exp_s;
                end
            end else begin
                total++;
                if (got_s !== last_s) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got=%h want=%h", c, got_s, last_s);
                end
            end
            total++;
            if (primed_o !== (fill_m >= 3)) begin
                bad++;
                $display("FAIL stall_primed cyc=%0d got=%b want=%b", c, primed_o, fill_m >= 3);
            end
        end
    endtask

    task automatic test_conj();
        logic [DW-1:0] ims [4];
        logic          cj  [4];
        ims = '{8'h80, 8'd37, 8'd0, 8'h80};
        cj  = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_clear();
        delay_i = 3'd1; enh = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            conjh_i = cj[i]; dataRe_i = 8'(8'h40 + i); dataIm_i = ims[i];
            q.push_back('{re: dataRe_i, im: cj[i] ? conj_model(ims[i]) : ims[i], v: 1'b1});
            step();
            exp_s = q.pop_front();
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL conj idx=%0d got=%h want=%h", i, got_s, exp_s);
            end
        end
        conjh_i = 1'b0;
    endtask

    task automatic test_tap();
        logic [SW-1:0] taps [5];
        int            idx  [5];
        taps = '{3'd0, 3'd4, 3'd7, 3'd2, 3'd1};
        idx  = '{0, 3, 3, 1, 0};
        do_clear();
        enh = 1'b1; valid_i = 1'b1; delay_i = 3'd1;
        for (int i = 0; i < DEPTH; i++) begin
            dataRe_i = 8'(16 + i); dataIm_i = 8'(32 + i);
            q.push_back('{re: dataRe_i, im: dataIm_i, v: 1'b1});
            step();
        end
        enh = 1'b0;
        for (int t = 0; t < 5; t++) begin
            delay_i = taps[t];
            #1;
            got_s = '{re: dataRe_o, im: dataIm_o, v: valid_o};
            exp_s = q[q.size() - 1 - idx[t]];
            total++;
            if (got_s !== exp_s) begin
                bad++;
                $display("FAIL tap_sel delay=%0d got=%h want=%h", taps[t], got_s, exp_s);
            end
            total++;
            if (primed_o !== 1'b1) begin
                bad++;
                $display("FAIL tap_primed delay=%0d got=%b want=1", taps[t], primed_o);
            end
        end
    endtask

    task automatic test_valid_clear();
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_clear();
        delay_i = 3'd2; enh = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_i = pat[i]; dataRe_i = 8'(50 + i); dataIm_i = 8'(60 + i);
            q.push_back('{re: dataRe_i, im: dataIm_i, v: pat[i]});
            step();
            if (q.size() == 2) begin
                exp_s = q.pop_front();
                total++;
                if (got_s !== exp_s) begin
                    bad++;
                    $display("FAIL valid_track edge=%0d got=%h want=%h", i, got_s, exp_s);
                end
            end
        end
        // Clear together with enable; this sample must never show up.
        clrh = 1'b1; valid_i = 1'b1; dataRe_i = 8'd99; dataIm_i = 8'd99;
        step();
        clrh = 1'b0; enh = 1'b0; q.delete();
        for (int d = 1; d <= DEPTH; d++) begin
            delay_i = SW'(d);
            #1;
            total++;
            if ({valid_o, primed_o, dataRe_o} !== {1'b0, 1'b0, 8'd0}) begin
                bad++;
                $display("FAIL clear_state tap=%0d got v=%b p=%b re=%h want 0 0 00",
                         d, valid_o, primed_o, dataRe_o);
            end
        end
        enh = 1'b1; valid_i = 1'b0; dataRe_i = '0; dataIm_i = '0;
        for (int c = 0; c < DEPTH; c++) begin
            step();
            total++;
            if (got_s !== sample_t'(0)) begin
                bad++;
                $display("FAIL clear_discard cyc=%0d got=%h want=0", c, got_s);
            end
        end
    endtask

    initial begin
        clrh = 1'b1; enh = 1'b0; conjh_i = 1'b0; valid_i = 1'b0;
        delay_i = '0; dataRe_i = '0; dataIm_i = '0; fill_m = 0;
        test_reset();
        test_latency();
        test_stall();
        test_conj();
        test_tap();
        test_valid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
